// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port between
// two writeback requesters. Also flags read/write address hazards and counts committed writes.
module regfile_write_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int ZERO_REG_RO = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_regwrite,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_hazard1,
  output logic              rd_hazard2,
  output logic [CNT_W-1:0]  write_count
);

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_grant_e;

  last_grant_e       last_grant;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              commit;

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!stall) begin
      if (req0_valid && req1_valid) begin
        grant0 = (last_grant == LAST_REQ1);
        grant1 = (last_grant == LAST_REQ0);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    win_addr = grant1 ? req1_addr : req0_addr;
    win_data = grant1 ? req1_data : req0_data;
    // Writes to r0 are still consumed so the requester is not blocked forever.
    commit   = (grant0 || grant1) && !((ZERO_REG_RO != 0) && (win_addr == '0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant  <= LAST_REQ1;
      rf_regwrite <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      write_count <= '0;
    end else begin
      if (grant0) begin
        last_grant <= LAST_REQ0;
      end else if (grant1) begin
        last_grant <= LAST_REQ1;
      end
      rf_regwrite <= commit;
      if (commit) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
      if (rf_regwrite && (write_count != '1)) begin
        write_count <= write_count + CNT_W'(1);
      end
    end
  end

  assign rd_hazard1 = rf_regwrite && (rd_addr1 == rf_waddr);
  assign rd_hazard2 = rf_regwrite && (rd_addr2 == rf_waddr);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference arbiter model pushes the
// expected write-stage state per cycle; each test pops and compares it.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_regwrite;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        rd_hazard1, rd_hazard2;
  logic [7:0]  write_count;

  regfile_write_arbiter #(
    .DATA_W(16),
    .ADDR_W(4),
    .ZERO_REG_RO(1),
    .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_regwrite(rf_regwrite), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_hazard1(rd_hazard1), .rd_hazard2(rd_hazard2),
    .write_count(write_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rw;
    logic [3:0]  a;
    logic [15:0] d;
    logic [7:0]  c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state; m_last=1 means req1 won last, so req0 wins next contention
  logic        m_last;
  logic        m_rw;
  logic [3:0]  m_a;
  logic [15:0] m_d;
  logic [7:0]  m_cnt;

  logic g0, g1, e0, e1;
  exp_t x;

  function automatic exp_t pop_exp();
    exp_t r;
    r = '{1'b0, 4'h0, 16'h0, 8'h0};
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty got=0 entries need>=1");
    end else begin
      r = sb.pop_front();
    end
    return r;
  endfunction

  task automatic model_reset();
    m_last = 1'b1;
    m_rw   = 1'b0;
    m_a    = '0;
    m_d    = '0;
    m_cnt  = '0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  // Drives one cycle of stimulus, samples readies at negedge, advances the model.
  task automatic step(input logic st,
                      input logic v0, input logic [3:0] a0, input logic [15:0] d0,
                      input logic v1, input logic [3:0] a1, input logic [15:0] d1);
    logic [3:0]  wa;
    logic [15:0] wd;
    stall = st;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    @(negedge clock);
    g0 = req0_ready;
    g1 = req1_ready;
    e0 = !st && v0 && (!v1 || m_last);
    e1 = !st && v1 && (!v0 || !m_last);
    @(posedge clock);
    if (m_rw && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    m_rw = 1'b0;
    if (e0 || e1) begin
      m_last = e1;
      wa = e1 ? a1 : a0;
      wd = e1 ? d1 : d0;
      if (wa != 4'h0) begin
        m_rw = 1'b1;
        m_a  = wa;
        m_d  = wd;
      end
    end
    sb.push_back('{m_rw, m_a, m_d, m_cnt});
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr1 = '0;
    rd_addr2 = '0;
    reset = 1'b0;
    model_reset();
    #3;
    total++;
    if ({rf_regwrite, rf_waddr, rf_wdata, write_count} !== 29'h0) begin
      bad++;
      $display("FAIL reset_state got rw=%b a=%h d=%h c=%h need all zero",
               rf_regwrite, rf_waddr, rf_wdata, write_count);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_write();
    step(1'b0, 1'b1, 4'd1, 16'h0010, 1'b0, 4'd0, 16'h0);
    total++;
    if ({g0, g1} !== {e0, e1} || g0 !== 1'b1) begin
      bad++;
      $display("FAIL single_ready got=%b%b need=%b%b", g0, g1, e0, e1);
    end
    x = pop_exp();
    total++;
    if ({rf_regwrite, rf_waddr, rf_wdata, write_count} !== {x.rw, x.a, x.d, x.c}) begin
      bad++;
      $display("FAIL single_write got rw=%b a=%h d=%h c=%0d need rw=%b a=%h d=%h c=%0d",
               rf_regwrite, rf_waddr, rf_wdata, write_count, x.rw, x.a, x.d, x.c);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    x = pop_exp();
    total++;
    if (write_count !== x.c || write_count !== 8'd1 || rf_regwrite !== x.rw) begin
      bad++;
      $display("FAIL single_count got rw=%b c=%0d need rw=%b c=%0d",
               rf_regwrite, write_count, x.rw, x.c);
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd1, 16'h2222, 1'b1, 4'd2, 16'hFFFF);
      total++;
      if ({g0, g1} !== {e0, e1} || g0 !== (i % 2 == 0)) begin
        bad++;
        $display("FAIL contention_ready[%0d] got=%b%b need=%b%b", i, g0, g1, e0, e1);
      end
      x = pop_exp();
      total++;
      if ({rf_regwrite, rf_waddr, rf_wdata, write_count} !== {x.rw, x.a, x.d, x.c} ||
          rf_wdata !== ((i % 2 == 0) ? 16'h2222 : 16'hFFFF)) begin
        bad++;
        $display("FAIL contention_write[%0d] got rw=%b a=%h d=%h c=%0d need rw=%b a=%h d=%h c=%0d",
                 i, rf_regwrite, rf_waddr, rf_wdata, write_count, x.rw, x.a, x.d, x.c);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'd1, 16'h2222, 1'b1, 4'd2, 16'hFFFF);
      x = pop_exp();
      total++;
      if ({g0, g1} !== 2'b00 || rf_regwrite !== 1'b0 || write_count !== x.c) begin
        bad++;
        $display("FAIL stall[%0d] got rdy=%b%b rw=%b c=%0d need rdy=00 rw=0 c=%0d",
                 i, g0, g1, rf_regwrite, write_count, x.c);
      end
    end
    step(1'b0, 1'b1, 4'd1, 16'h2222, 1'b1, 4'd2, 16'hFFFF);
    x = pop_exp();
    total++;
    if ({g0, g1} !== {e0, e1} || g0 !== 1'b1 || rf_wdata !== x.d || rf_regwrite !== x.rw) begin
      bad++;
      $display("FAIL stall_resume got rdy=%b%b d=%h need rdy=%b%b d=%h",
               g0, g1, rf_wdata, e0, e1, x.d);
    end
  endtask

  task automatic test_zero_reg();
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h1111);
    x = pop_exp();
    total++;
    if (g1 !== 1'b1 || g0 !== 1'b0 || rf_regwrite !== 1'b0 || rf_wdata !== x.d) begin
      bad++;
      $display("FAIL zero_reg got rdy1=%b rw=%b d=%h need rdy1=1 rw=0 d=%h",
               g1, rf_regwrite, rf_wdata, x.d);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    x = pop_exp();
    total++;
    if (write_count !== x.c || rf_regwrite !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg_count got c=%0d rw=%b need c=%0d rw=0",
               write_count, rf_regwrite, x.c);
    end
  endtask

  task automatic test_hazard();
    step(1'b0, 1'b1, 4'd3, 16'hABCD, 1'b0, 4'd0, 16'h0);
    x = pop_exp();
    rd_addr1 = 4'd3;
    rd_addr2 = 4'd4;
    #1;
    total++;
    if (rf_regwrite !== 1'b1 || rf_waddr !== 4'd3 || rd_hazard1 !== 1'b1 || rd_hazard2 !== 1'b0) begin
      bad++;
      $display("FAIL hazard_hit got rw=%b a=%h h1=%b h2=%b need rw=1 a=3 h1=1 h2=0",
               rf_regwrite, rf_waddr, rd_hazard1, rd_hazard2);
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    x = pop_exp();
    total++;
    if (rd_hazard1 !== 1'b0 || rd_hazard2 !== 1'b0 || rf_waddr !== x.a) begin
      bad++;
      $display("FAIL hazard_idle got h1=%b h2=%b a=%h need h1=0 h2=0 a=%h",
               rd_hazard1, rd_hazard2, rf_waddr, x.a);
    end
    rd_addr1 = '0;
    rd_addr2 = '0;
  endtask

  task automatic test_reset_mid_write();
    step(1'b0, 1'b1, 4'd6, 16'h0606, 1'b0, 4'd0, 16'h0);
    x = pop_exp();
    step(1'b0, 1'b1, 4'd7, 16'h0707, 1'b0, 4'd0, 16'h0);
    x = pop_exp();
    total++;
    if (rf_regwrite !== 1'b1 || write_count !== x.c || write_count == 8'd0) begin
      bad++;
      $display("FAIL pre_reset got rw=%b c=%0d need rw=1 c=%0d", rf_regwrite, write_count, x.c);
    end
    idle_inputs();
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (rf_regwrite !== 1'b0 || write_count !== 8'd0) begin
      bad++;
      $display("FAIL async_reset got rw=%b c=%0d need rw=0 c=0", rf_regwrite, write_count);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 1'b1, 4'd5, 16'(i), 1'b0, 4'd0, 16'h0);
      x = pop_exp();
      total++;
      if ({rf_regwrite, rf_waddr, rf_wdata, write_count} !== {x.rw, x.a, x.d, x.c}) begin
        bad++;
        $display("FAIL sat_write[%0d] got rw=%b a=%h d=%h c=%0d need rw=%b a=%h d=%h c=%0d",
                 i, rf_regwrite, rf_waddr, rf_wdata, write_count, x.rw, x.a, x.d, x.c);
      end
    end
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    x = pop_exp();
    total++;
    if (write_count !== 8'hFF || write_count !== x.c) begin
      bad++;
      $display("FAIL saturate got c=%h need c=ff", write_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_reset();
    test_contention();
    test_stall();
    test_zero_reg();
    test_hazard();
    test_reset_mid_write();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running need=finished");
    $fatal(1);
  end

endmodule
